multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 32, width of the retired-instruction counter.
REQ-002 SHALL have port clk  input  1  rising-edge clock; the block has one clock.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-005 SHALL have port funct  input  6  instruction bits [5:0].
REQ-006 SHALL have port zero  input  1  ALU zero flag.
REQ-007 SHALL have outputs iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, pc_en, each 1 bit, driving the datapath muxes and enables.
REQ-008 SHALL have outputs alu_src_b (2 bits), pc_src (2 bits) and alu_control (3 bits: 000 and, 001 or, 010 add, 110 sub, 111 slt).
REQ-009 SHALL have outputs illegal_op (1 bit), instr_count (CNT_WIDTH bits) and state (4 bits, debug).

Function
REQ-010 SHALL be a Moore FSM; outputs decode from state only, except alu_control in RTYPEEX (depends on funct) and pc_en in BEQEX (depends on zero).
REQ-011 SHALL use states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX, encoded 0..11.
REQ-012 SHALL transition FETCH->DECODE unconditionally.
REQ-013 SHALL transition from DECODE on opcode: 100011 or 101011 ->MEMADR, 000000 ->RTYPEEX, 000100 ->BEQEX, 001000 ->ADDIEX, 000010 ->JEX, any other value ->FETCH.
REQ-014 SHALL transition MEMADR->MEMRD on lw, otherwise ->MEMWR; MEMRD->MEMWB; RTYPEEX->RTYPEWB; ADDIEX->ADDIWB.
REQ-015 SHALL transition MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB and JEX ->FETCH.
REQ-016 SHALL drive output defaults of 0 in every state, with alu_control=010 and alu_src_b=00.
REQ-017 SHALL drive FETCH: ir_write=1, pc_en=1, alu_src_b=01, pc_src=00.
REQ-018 SHALL drive DECODE: alu_src_b=11; MEMADR and ADDIEX: alu_src_a=1, alu_src_b=10.
REQ-019 SHALL drive MEMRD: iord=1; MEMWR: iord=1, mem_write=1; MEMWB: mem_to_reg=1, reg_write=1.
REQ-020 SHALL drive RTYPEEX: alu_src_a=1, with alu_control from funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; RTYPEWB: reg_dst=1, reg_write=1.
REQ-021 SHALL drive BEQEX: alu_src_a=1, alu_control=110, pc_src=01, pc_en=zero; ADDIWB: reg_write=1; JEX: pc_src=10, pc_en=1.
REQ-022 SHALL assert illegal_op for one cycle in DECODE on an unlisted opcode, and in RTYPEEX on an unlisted funct; in the RTYPEEX case it SHALL go to FETCH with no writeback.
REQ-023 SHALL have total latencies, FETCH to FETCH: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2 (3 for bad funct).
REQ-024 SHALL increment instr_count by 1 on each transition into FETCH from a state in REQ-015; illegal returns SHALL NOT count; the count SHALL wrap modulo 2^CNT_WIDTH.

Reset
REQ-025 SHALL, on a clk edge with reset_n=0, load state=FETCH and instr_count=0, aborting any in-flight instruction.
REQ-026 SHALL force mem_write, ir_write, reg_write, pc_en and illegal_op to 0 while reset_n=0.
REQ-027 SHALL perform the first fetch in the first cycle after reset_n rises.

Configuration
REQ-028 SHALL use macro JUMP_EN; when it is defined, opcode 000010 SHALL follow DECODE->JEX->FETCH.
REQ-029 SHALL, without JUMP_EN, omit JEX, treat opcode 000010 as illegal per REQ-022, and never drive pc_src=10.

Structure
REQ-030 SHALL place the state enum, opcode constants, funct constants and alu_control constants in package multicycle_pkg.
REQ-031 SHALL implement the funct-to-alu_control decode in sub-module alu_decoder, which also flags an unlisted funct.

Verification
REQ-032 SHALL test reset then lw (opcode 100011): states 0,1,2,3,4,0; reg_write=1 only in MEMWB; instr_count=1.
REQ-033 SHALL test sw (101011): mem_write=1 for exactly one cycle in MEMWR with iord=1; no reg_write in any cycle.
REQ-034 SHALL test R-type with funct 100010 then 101010: alu_control=110 then 111 in RTYPEEX; with funct 000111, illegal_op=1, no reg_write, return to FETCH.
REQ-035 SHALL test beq with zero=1 (pc_en=1, pc_src=01 in BEQEX) and with zero=0 (pc_en=0); both count as retired.
REQ-036 SHALL test opcode 000010: with JUMP_EN, JEX sets pc_src=10, pc_en=1; without JUMP_EN, illegal_op=1 in DECODE and instr_count is unchanged.
REQ-037 SHALL test reset_n=0 asserted in MEMRD (state FETCH next cycle, instr_count=0) and CNT_WIDTH=4 with 16 retirements (wraps to 0).

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle control unit.
// JUMP_EN adds the JEX state for the j opcode.
package multicycle_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRtypeEx = 4'd6,
    StRtypeWb = 4'd7,
    StBeqEx   = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10
`ifdef JUMP_EN
    , StJex   = 4'd11
`endif
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [5:0] FunctAdd = 6'b100000;
  localparam logic [5:0] FunctSub = 6'b100010;
  localparam logic [5:0] FunctAnd = 6'b100100;
  localparam logic [5:0] FunctOr  = 6'b100101;
  localparam logic [5:0] FunctSlt = 6'b101010;

  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct field to ALU operation decode; flags funct values with no mapping.
module alu_decoder
  import multicycle_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_control,
  output logic       o_illegal
);

  always_comb begin
    o_alu_control = AluAdd;
    o_illegal     = 1'b0;
    case (i_funct)
      FunctAdd: o_alu_control = AluAdd;
      FunctSub: o_alu_control = AluSub;
      FunctAnd: o_alu_control = AluAnd;
      FunctOr:  o_alu_control = AluOr;
      FunctSlt: o_alu_control = AluSlt;
      default:  o_illegal     = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-style datapath with a retired-instruction counter.
// Define JUMP_EN to support the j opcode; otherwise it decodes as illegal.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  output logic                 iord,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic                 pc_en,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           pc_src,
  output logic [2:0]           alu_control,
  output logic                 illegal_op,
  output logic [CNT_WIDTH-1:0] instr_count,
  output logic [3:0]           state
);

  state_e               r_state, w_state_next;
  logic [CNT_WIDTH-1:0] r_instr_count;
  logic                 w_retire;
  logic                 w_mem_write, w_ir_write, w_reg_write, w_pc_en, w_illegal;
  logic [2:0]           w_dec_alu_control;
  logic                 w_dec_illegal;

  alu_decoder u_alu_decoder (
    .i_funct       (funct),
    .o_alu_control (w_dec_alu_control),
    .o_illegal     (w_dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= StFetch;
      r_instr_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_retire) r_instr_count <= r_instr_count + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_retire     = 1'b0;
    iord         = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    w_reg_write  = 1'b0;
    alu_src_a    = 1'b0;
    w_pc_en      = 1'b0;
    alu_src_b    = 2'b00;
    pc_src       = 2'b00;
    alu_control  = AluAdd;
    w_illegal    = 1'b0;
    unique case (r_state)
      StFetch: begin
        w_ir_write   = 1'b1;
        w_pc_en      = 1'b1;
        alu_src_b    = 2'b01;
        w_state_next = StDecode;
      end
      StDecode: begin
        alu_src_b = 2'b11;
        case (opcode)
          OpLw, OpSw: w_state_next = StMemAdr;
          OpRtype:    w_state_next = StRtypeEx;
          OpBeq:      w_state_next = StBeqEx;
          OpAddi:     w_state_next = StAddiEx;
`ifdef JUMP_EN
          OpJ:        w_state_next = StJex;
`endif
          default: begin
            w_illegal    = 1'b1;
            w_state_next = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b10;
        w_state_next = (opcode == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        iord         = 1'b1;
        w_state_next = StMemWb;
      end
      StMemWb: begin
        mem_to_reg   = 1'b1;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
        w_state_next = StFetch;
      end
      StMemWr: begin
        iord         = 1'b1;
        w_mem_write  = 1'b1;
        w_retire     = 1'b1;
        w_state_next = StFetch;
      end
      StRtypeEx: begin
        alu_src_a   = 1'b1;
        alu_control = w_dec_alu_control;
        // A bad funct abandons the instruction: no writeback, not counted.
        if (w_dec_illegal) begin
          w_illegal    = 1'b1;
          w_state_next = StFetch;
        end else begin
          w_state_next = StRtypeWb;
        end
      end
      StRtypeWb: begin
        reg_dst      = 1'b1;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
        w_state_next = StFetch;
      end
      StBeqEx: begin
        alu_src_a    = 1'b1;
        alu_control  = AluSub;
        pc_src       = 2'b01;
        w_pc_en      = zero;
        w_retire     = 1'b1;
        w_state_next = StFetch;
      end
      StAddiEx: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b10;
        w_state_next = StAddiWb;
      end
      StAddiWb: begin
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
        w_state_next = StFetch;
      end
`ifdef JUMP_EN
      StJex: begin
        pc_src       = 2'b10;
        w_pc_en      = 1'b1;
        w_retire     = 1'b1;
        w_state_next = StFetch;
      end
`endif
      default: w_state_next = StFetch;
    endcase
  end

  // Write strobes are held off for the whole time reset is low, not just after the edge.
  assign mem_write   = w_mem_write & reset_n;
  assign ir_write    = w_ir_write & reset_n;
  assign reg_write   = w_reg_write & reset_n;
  assign pc_en       = w_pc_en & reset_n;
  assign illegal_op  = w_illegal & reset_n;
  assign instr_count = r_instr_count;
  assign state       = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expectations queued by stimulus, checked
// by a negedge monitor on a 32-bit and a 4-bit counter instance. Honours JUMP_EN.
module tb_multicycle_control;

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] cw;
    logic [31:0] cnt;
  } exp_t;

  logic        clk, reset_n, zero;
  logic [5:0]  opcode, funct;
  logic        iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, pc_en;
  logic [1:0]  alu_src_b, pc_src;
  logic [2:0]  alu_control;
  logic        illegal_op;
  logic [31:0] instr_count;
  logic [3:0]  state;

  logic        iord4, mem_write4, ir_write4, reg_dst4, mem_to_reg4, reg_write4;
  logic        alu_src_a4, pc_en4, illegal_op4;
  logic [1:0]  alu_src_b4, pc_src4;
  logic [2:0]  alu_control4;
  logic [3:0]  instr_count4;
  logic [3:0]  state4;

  exp_t        sb[$];
  logic [31:0] ecnt;
  int          n_checks, n_pass;

  multicycle_control dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
    .iord(iord), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a), .pc_en(pc_en),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_control(alu_control),
    .illegal_op(illegal_op), .instr_count(instr_count), .state(state)
  );

  multicycle_control #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
    .iord(iord4), .mem_write(mem_write4), .ir_write(ir_write4), .reg_dst(reg_dst4),
    .mem_to_reg(mem_to_reg4), .reg_write(reg_write4), .alu_src_a(alu_src_a4),
    .pc_en(pc_en4), .alu_src_b(alu_src_b4), .pc_src(pc_src4), .alu_control(alu_control4),
    .illegal_op(illegal_op4), .instr_count(instr_count4), .state(state4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] cw(input logic iord_e, mw, irw, rd, m2r, rw, asa, pe,
                                     input logic [1:0] asb, ps, input logic [2:0] ac,
                                     input logic il);
    return {iord_e, mw, irw, rd, m2r, rw, asa, pe, asb, ps, ac, il};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
  endtask

  // Push the expectation for the current cycle, then advance to just after the next edge.
  task automatic chk(input logic [3:0] st, input logic [15:0] w);
    exp_t e;
    e.st  = st;
    e.cw  = w;
    e.cnt = ecnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check("state", 32'(state), 32'(e.st));
      check("ctrl", 32'({iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                         pc_en, alu_src_b, pc_src, alu_control, illegal_op}), 32'(e.cw));
      check("instr_count", instr_count, e.cnt);
      check("state_w4", 32'(state4), 32'(e.st));
      check("ctrl_w4", 32'({iord4, mem_write4, ir_write4, reg_dst4, mem_to_reg4, reg_write4,
                            alu_src_a4, pc_en4, alu_src_b4, pc_src4, alu_control4,
                            illegal_op4}), 32'(e.cw));
      check("instr_count_w4", 32'(instr_count4), 32'(e.cnt[3:0]));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w_rst, w_f, w_d, w_dil, w_ma, w_mr, w_mwb, w_mw, w_rwb, w_awb;
    w_rst = cw(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0);
    w_f   = cw(0, 0, 1, 0, 0, 0, 0, 1, 2'b01, 2'b00, 3'b010, 0);
    w_d   = cw(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 0);
    w_dil = cw(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 1);
    w_ma  = cw(0, 0, 0, 0, 0, 0, 1, 0, 2'b10, 2'b00, 3'b010, 0);
    w_mr  = cw(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0);
    w_mwb = cw(0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 3'b010, 0);
    w_mw  = cw(1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0);
    w_rwb = cw(0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 3'b010, 0);
    w_awb = cw(0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 3'b010, 0);
    n_checks = 0;
    n_pass   = 0;
    ecnt     = 0;
    reset_n  = 1'b0;
    opcode   = 6'b000000;
    funct    = 6'b000000;
    zero     = 1'b0;
    @(posedge clk);
    #1;
    chk(4'd0, w_rst);
    reset_n = 1'b1;

    opcode = 6'b100011;  // lw
    chk(4'd0, w_f); chk(4'd1, w_d); chk(4'd2, w_ma); chk(4'd3, w_mr); chk(4'd4, w_mwb);
    ecnt++;
    opcode = 6'b101011;  // sw
    chk(4'd0, w_f); chk(4'd1, w_d); chk(4'd2, w_ma); chk(4'd5, w_mw);
    ecnt++;
    opcode = 6'b000000;  // R-type sub, slt, bad funct
    funct  = 6'b100010;
    chk(4'd0, w_f); chk(4'd1, w_d);
    chk(4'd6, cw(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b110, 0)); chk(4'd7, w_rwb);
    ecnt++;
    funct = 6'b101010;
    chk(4'd0, w_f); chk(4'd1, w_d);
    chk(4'd6, cw(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b111, 0)); chk(4'd7, w_rwb);
    ecnt++;
    funct = 6'b000111;
    chk(4'd0, w_f); chk(4'd1, w_d);
    chk(4'd6, cw(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b010, 1));
    opcode = 6'b001000;  // addi
    chk(4'd0, w_f); chk(4'd1, w_d); chk(4'd9, w_ma); chk(4'd10, w_awb);
    ecnt++;
    opcode = 6'b000100;  // beq taken, then not taken
    zero   = 1'b1;
    chk(4'd0, w_f); chk(4'd1, w_d);
    chk(4'd8, cw(0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b01, 3'b110, 0));
    ecnt++;
    zero = 1'b0;
    chk(4'd0, w_f); chk(4'd1, w_d);
    chk(4'd8, cw(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 3'b110, 0));
    ecnt++;
    opcode = 6'b000010;  // j
    chk(4'd0, w_f);
`ifdef JUMP_EN
    chk(4'd1, w_d);
    chk(4'd11, cw(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 3'b010, 0));
    ecnt++;
`else
    chk(4'd1, w_dil);
`endif
    opcode = 6'b111111;  // unlisted opcode
    chk(4'd0, w_f); chk(4'd1, w_dil);

    opcode = 6'b100011;  // lw aborted by reset in MEMRD
    chk(4'd0, w_f); chk(4'd1, w_d); chk(4'd2, w_ma);
    reset_n = 1'b0;
    chk(4'd3, w_mr);
    ecnt = 0;
    chk(4'd0, w_rst);
    reset_n = 1'b1;

    opcode = 6'b000100;  // 16 retirements wrap the 4-bit counter
    zero   = 1'b1;
    repeat (16) begin
      chk(4'd0, w_f); chk(4'd1, w_d);
      chk(4'd8, cw(0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b01, 3'b110, 0));
      ecnt++;
    end
    chk(4'd0, w_f);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
